iccm_dumper: RTL and testbench
==============================

# iccm_dumper

Memory readback engine: on a `dump_i` pulse it reads a range of 32-bit words from an instruction/data SRAM through the SRAM's native port and serializes them out a UART transmit line. It is the transmit-side counterpart of the UART instruction loader: the loader writes words received on UART into ICCM, and this block sends ICCM/DCCM contents back out for boot-image verification and post-mortem dumps. It sits beside the loader, muxed onto the SRAM port while the core is held in reset.

## Interface
- `ADDR_W`, 12: SRAM word-address width.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `clks_per_bit_i`  in  16  UART bit period in `clk_i` cycles; a value of 0 is treated as 1.
- `dump_i`  in  1  start request; sampled only in IDLE.
- `start_addr_i`  in  ADDR_W  first word address; latched on start.
- `num_words_i`  in  ADDR_W+1  number of words, 0..4096; latched on start.
- `csb_o`  out  1  SRAM chip select, active-low; reset 1.
- `addr_o`  out  ADDR_W  SRAM word address; reset 0.
- `rdata_i`  in  32  SRAM read data; valid in the cycle after `csb_o`=0.
- `tx_o`  out  1  UART TX line; reset 1 (idle mark).
- `busy_o`  out  1  high in every state except IDLE; reset 0.
- `done_o`  out  1  one-cycle pulse when a dump completes; reset 0.

## Operation
- Frame format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1). Each bit holds for B = max(`clks_per_bit_i`,1) cycles.
- `clks_per_bit_i` is sampled at each bit boundary. Changing it while busy is unsupported.
- Word byte order: little-endian. Bytes are sent as `rdata[7:0]`, then `[15:8]`, `[23:16]`, `[31:24]`.
- FSM states:
  - IDLE: on `dump_i`=1, latch address and count. If count=0, go to FIN. Otherwise go to RD_REQ.
  - RD_REQ: drive `csb_o`=0 and `addr_o`=current address for exactly one cycle.
  - RD_WAIT: capture `rdata_i` into the word buffer and set byte index to 0.
  - START, DATA, STOP: transmit one frame of the current byte.
  - After STOP:
    - If byte index < 3: increment the index and go to START.
    - Else decrement the remaining count and increment the address (mod 2^ADDR_W; 4095 wraps to 0).
    - If remaining > 0: go to RD_REQ.
    - If remaining = 0: go to CSUM (when configured) or FIN.
  - FIN: pulse `done_o` for one cycle, then go to IDLE.
- `dump_i` asserted while busy is ignored. It is not queued.
- `csb_o` is 1 in every state other than RD_REQ. No writes are ever issued.
- `rst_i` mid-dump takes effect immediately:
  - `tx_o` goes to 1 and `csb_o` goes to 1.
  - The FSM returns to IDLE.
  - A truncated frame on the line is acceptable.

## Timing
- With `dump_i` high at clock edge E0 in IDLE:
  - `csb_o`=0 during cycle E0..E1.
  - Read data is captured at E2.
  - `tx_o` falls at E2.
- Each byte takes 10·B cycles, with no gap between the bytes of a word.
- Inter-word gap: 2 cycles of `tx_o`=1 (RD_REQ, RD_WAIT).
- `busy_o` rises at E0+1.
- `done_o` pulses in the cycle after the final stop bit ends. `busy_o` falls one cycle after that pulse.
- Dump with count=0: `done_o` at E0+1, `csb_o` never asserted, `tx_o` stays 1.
- Total N-word dump with the checksum option disabled, in cycles from E0 until `done_o` is high: N·(2 + 40·B) + 1.

## Configuration
- `ICCM_DUMPER_CHECKSUM_EN` defined:
  - After the last word, the CSUM state sends one extra 8N1 frame with no preceding gap.
  - The frame carries the 8-bit modular sum of all data bytes sent in this dump.
  - For count=0 the checksum byte 0x00 is sent before FIN.
- `ICCM_DUMPER_CHECKSUM_EN` not defined:
  - The CSUM state and the sum register do not exist.
  - The dump ends at the last data byte.

## Test plan
- Single word: SRAM[0x010]=0x12345678, B=4, start=0x010, N=1. Expected:
  - `tx_o` frames carry bytes 0x78, 0x56, 0x34, 0x12.
  - `done_o` at E0+163.
  - `csb_o` low for exactly one cycle with `addr_o`=0x010.
- Multi-word with wrap: start=0xFFE, N=4, B=1. Expected:
  - Reads in the order 0xFFE, 0xFFF, 0x000, 0x001.
  - Two idle-high cycles between words.
  - 16 bytes total.
- Zero count: N=0. Expected:
  - `done_o` at E0+1.
  - No SRAM access.
  - `tx_o` constant 1.
  - With checksum enabled, exactly one frame carrying 0x00.
- Busy re-trigger: pulse `dump_i` again mid-dump with a different start address. Expected: the output byte stream is identical to the undisturbed run, and there is exactly one `done_o`.
- Reset mid-dump: assert `rst_i` during a DATA bit of byte 2. Expected:
  - `tx_o`=1, `csb_o`=1, `busy_o`=0 asynchronously.
  - A new dump afterwards starts cleanly from its own start address.
- Checksum (enabled): words 0x01020304 and 0xFFFFFFFF, N=2. Expected: final frame carries 0x06 (0x0A + 0x3FC mod 256).

Source files
------------

// File: rtl/iccm_dumper_if.sv
// Bus bundle for iccm_dumper: dump control, SRAM native read port and UART TX.
// The slave modport is the dumper's view; master is the controller/SRAM/UART side.
interface iccm_dumper_if #(
  parameter int ADDR_W = 12
);
  logic [15:0]       clks_per_bit_i;
  logic              dump_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic [ADDR_W:0]   num_words_i;
  logic              csb_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       rdata_i;
  logic              tx_o;
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  clks_per_bit_i, dump_i, start_addr_i, num_words_i, rdata_i,
    output csb_o, addr_o, tx_o, busy_o, done_o
  );

  modport master (
    output clks_per_bit_i, dump_i, start_addr_i, num_words_i, rdata_i,
    input  csb_o, addr_o, tx_o, busy_o, done_o
  );
endinterface

// File: rtl/iccm_dumper.sv
// SRAM readback engine: reads N words and streams them little-endian as 8N1 UART frames.
// Optional trailing 8-bit modular checksum frame when ICCM_DUMPER_CHECKSUM_EN is defined.
module iccm_dumper #(
  parameter int ADDR_W = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  iccm_dumper_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_START,
    S_DATA,
    S_STOP,
`ifdef ICCM_DUMPER_CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       bper_q, bper_d;
  logic [15:0]       bper_eff;
  logic              bit_end;
  logic              in_bit;
  logic [7:0]        cur_byte;
  logic              csb_c, tx_c, done_c;
`ifdef ICCM_DUMPER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic [2:0]        sbit;
  assign sbit = 3'(bit_q - 4'd1);
`endif

  localparam logic [ADDR_W:0]   REM_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  assign bper_eff = (bus.clks_per_bit_i == 16'd0) ? 16'd1 : bus.clks_per_bit_i;
  assign bit_end  = (cnt_q == bper_q - 16'd1);
  assign cur_byte = word_q[{byte_q, 3'b000} +: 8];

  assign bus.csb_o  = csb_c;
  assign bus.addr_o = addr_q;
  assign bus.tx_o   = tx_c;
  assign bus.done_o = done_c;
  assign bus.busy_o = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    word_d   = word_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    bper_d   = bper_q;
    in_bit   = 1'b0;
    csb_c    = 1'b1;
    tx_c     = 1'b1;
    done_c   = 1'b0;
`ifdef ICCM_DUMPER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.dump_i) begin
          addr_d   = bus.start_addr_i;
          remain_d = bus.num_words_i;
`ifdef ICCM_DUMPER_CHECKSUM_EN
          sum_d    = 8'h00;
          if (bus.num_words_i == '0) begin
            state_d = S_CSUM;
            bit_d   = 4'd0;
            cnt_d   = 16'd0;
            bper_d  = bper_eff;
          end else begin
            state_d = S_RD_REQ;
          end
`else
          state_d  = (bus.num_words_i == '0) ? S_FIN : S_RD_REQ;
`endif
        end
      end
      S_RD_REQ: begin
        csb_c   = 1'b0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        word_d  = bus.rdata_i;
        byte_d  = 2'd0;
        cnt_d   = 16'd0;
        bper_d  = bper_eff;
        state_d = S_START;
      end
      S_START: begin
        in_bit = 1'b1;
        tx_c   = 1'b0;
        if (bit_end) begin
          bit_d   = 4'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_bit = 1'b1;
        tx_c   = cur_byte[bit_q[2:0]];
        if (bit_end) begin
          if (bit_q == 4'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 4'd1;
        end
      end
      S_STOP: begin
        in_bit = 1'b1;
        if (bit_end) begin
`ifdef ICCM_DUMPER_CHECKSUM_EN
          sum_d = sum_q + cur_byte;
`endif
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
          end else begin
            remain_d = remain_q - REM_ONE;
            addr_d   = addr_q + ADDR_ONE;
            // remain_q still holds the pre-decrement count here
            if (remain_q != REM_ONE) begin
              state_d = S_RD_REQ;
            end else begin
`ifdef ICCM_DUMPER_CHECKSUM_EN
              bit_d   = 4'd0;
              state_d = S_CSUM;
`else
              state_d = S_FIN;
`endif
            end
          end
        end
      end
`ifdef ICCM_DUMPER_CHECKSUM_EN
      // Whole checksum frame in one state: bit 0 start, 1..8 data, 9 stop
      S_CSUM: begin
        in_bit = 1'b1;
        if (bit_q == 4'd0)      tx_c = 1'b0;
        else if (bit_q == 4'd9) tx_c = 1'b1;
        else                    tx_c = sum_q[sbit];
        if (bit_end) begin
          if (bit_q == 4'd9) state_d = S_FIN;
          else               bit_d   = bit_q + 4'd1;
        end
      end
`endif
      S_FIN: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (in_bit) begin
      if (bit_end) begin
        cnt_d  = 16'd0;
        bper_d = bper_eff;
      end else begin
        cnt_d  = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      word_q   <= 32'h0;
      byte_q   <= 2'd0;
      bit_q    <= 4'd0;
      cnt_q    <= 16'd0;
      bper_q   <= 16'd1;
`ifdef ICCM_DUMPER_CHECKSUM_EN
      sum_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      word_q   <= word_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      bper_q   <= bper_d;
`ifdef ICCM_DUMPER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_iccm_dumper.sv
// Directed bench for iccm_dumper: SRAM model, UART frame decoder and per-scenario checks.
module tb_iccm_dumper;
  logic clk = 1'b0;
  logic rst = 1'b1;

  iccm_dumper_if #(.ADDR_W(12)) bus();
  iccm_dumper #(.ADDR_W(12)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef ICCM_DUMPER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic [31:0] mem [0:4095];
  int checks = 0, errors = 0;
  int cyc = 0, e0 = 0, b_cur = 1;
  int done_cnt = 0, done_cyc = 0, tx_low_cnt = 0, rx_n = 0;
  logic rx_on = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [11:0] rd_q[$];
  logic [7:0]  by_q[$];
  int          st_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (!bus.csb_o) bus.rdata_i <= mem[bus.addr_o];

  // Observer: SRAM reads, done pulses and UART frames sampled mid-bit
  always @(negedge clk) begin
    if (rst) begin
      rx_on = 1'b0;
    end else begin
      if (!bus.csb_o) rd_q.push_back(bus.addr_o);
      if (bus.done_o) begin done_cnt++; done_cyc = cyc; end
      if (!bus.tx_o) tx_low_cnt++;
      if (!rx_on) begin
        if (!bus.tx_o) begin rx_on = 1'b1; rx_n = 0; rx_byte = 8'h00; st_q.push_back(cyc); end
      end else begin
        rx_n++;
        for (int k = 1; k <= 8; k++) if (rx_n == k*b_cur + b_cur/2) rx_byte[k-1] = bus.tx_o;
        if (rx_n == 9*b_cur + b_cur/2) begin by_q.push_back(rx_byte); rx_on = 1'b0; end
      end
    end
  end

  task automatic start_dump(input logic [11:0] a, input logic [12:0] n, input logic [15:0] cpb);
    @(negedge clk); #1;
    rd_q.delete(); by_q.delete(); st_q.delete();
    done_cnt = 0; tx_low_cnt = 0;
    b_cur = (cpb == 16'd0) ? 1 : int'(cpb);
    bus.start_addr_i = a; bus.num_words_i = n; bus.clks_per_bit_i = cpb; bus.dump_i = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    bus.dump_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin @(negedge clk); #1; i++; end
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.csb_o !== 1'b1) begin errors++; $display("FAIL reset_csb got %b want 1", bus.csb_o); end
    checks++; if (bus.addr_o !== 12'h000) begin errors++; $display("FAIL reset_addr got %h want 000", bus.addr_o); end
    checks++; if (bus.tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", bus.tx_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    bit ok;
    mem[12'h010] = 32'h12345678;
    start_dump(12'h010, 13'd1, 16'd4);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b want 1", bus.busy_o); end
    checks++; if (bus.csb_o !== 1'b0) begin errors++; $display("FAIL single_csb got %b want 0", bus.csb_o); end
    checks++; if (bus.addr_o !== 12'h010) begin errors++; $display("FAIL single_addr got %h want 010", bus.addr_o); end
    wait_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout done never seen"); end
    checks++; if (done_cyc - e0 + 1 != 163 + CS*40) begin errors++; $display("FAIL single_done_lat got %0d want %0d", done_cyc - e0 + 1, 163 + CS*40); end
    @(posedge clk); #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", bus.busy_o); end
    checks++; if (rd_q.size() != 1) begin errors++; $display("FAIL single_reads got %0d want 1", rd_q.size()); end
    checks++; if (st_q.size() == 0 || st_q[0] - e0 != 2) begin errors++; $display("FAIL single_tx_fall got %0d want 2", st_q.size() ? st_q[0] - e0 : -1); end
    checks++; if (by_q.size() != 4 + CS) begin errors++; $display("FAIL single_nbytes got %0d want %0d", by_q.size(), 4 + CS); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (by_q[i] !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, by_q[i], exp_b[i]); end
    end
`ifdef ICCM_DUMPER_CHECKSUM_EN
    checks++; if (by_q[4] !== 8'h14) begin errors++; $display("FAIL single_csum got %h want 14", by_q[4]); end
`endif
  endtask

  task automatic test_wrap();
    logic [11:0] exp_a [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    logic [7:0] exp_b [16] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h44, 8'h33, 8'h22, 8'h11,
                               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
    bit ok;
    mem[12'hFFE] = 32'hA1B2C3D4; mem[12'hFFF] = 32'h11223344;
    mem[12'h000] = 32'hDEADBEEF; mem[12'h001] = 32'h0F1E2D3C;
    start_dump(12'hFFE, 13'd4, 16'd1);
    wait_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout done never seen"); end
    checks++; if (done_cyc - e0 + 1 != 169 + CS*10) begin errors++; $display("FAIL wrap_done_lat got %0d want %0d", done_cyc - e0 + 1, 169 + CS*10); end
    checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL wrap_nreads got %0d want 4", rd_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, rd_q[i], exp_a[i]); end
    end
    checks++; if (by_q.size() != 16 + CS) begin errors++; $display("FAIL wrap_nbytes got %0d want %0d", by_q.size(), 16 + CS); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (by_q[i] !== exp_b[i]) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", i, by_q[i], exp_b[i]); end
    end
    for (int i = 1; i < 16; i++) begin
      checks++; if (st_q[i] - st_q[i-1] != ((i % 4 == 0) ? 12 : 10)) begin errors++; $display("FAIL wrap_gap%0d got %0d want %0d", i, st_q[i] - st_q[i-1], (i % 4 == 0) ? 12 : 10); end
    end
  endtask

  task automatic test_zero_count();
    bit ok;
    start_dump(12'h123, 13'd0, 16'd3);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout done never seen"); end
    checks++; if (done_cyc - e0 + 1 != 1 + CS*30) begin errors++; $display("FAIL zero_done_lat got %0d want %0d", done_cyc - e0 + 1, 1 + CS*30); end
    repeat (5) @(negedge clk);
    checks++; if (rd_q.size() != 0) begin errors++; $display("FAIL zero_reads got %0d want 0", rd_q.size()); end
`ifdef ICCM_DUMPER_CHECKSUM_EN
    checks++; if (by_q.size() != 1) begin errors++; $display("FAIL zero_nbytes got %0d want 1", by_q.size()); end
    checks++; if (by_q[0] !== 8'h00) begin errors++; $display("FAIL zero_csum got %h want 00", by_q[0]); end
`else
    checks++; if (tx_low_cnt != 0) begin errors++; $display("FAIL zero_tx_low got %0d want 0", tx_low_cnt); end
`endif
  endtask

  task automatic test_cpb_zero();
    logic [7:0] exp_b [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    bit ok;
    mem[12'h020] = 32'h00FF00FF;
    start_dump(12'h020, 13'd1, 16'd0);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cpb0_timeout done never seen"); end
    checks++; if (done_cyc - e0 + 1 != 43 + CS*10) begin errors++; $display("FAIL cpb0_done_lat got %0d want %0d", done_cyc - e0 + 1, 43 + CS*10); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (by_q[i] !== exp_b[i]) begin errors++; $display("FAIL cpb0_byte%0d got %h want %h", i, by_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_busy_retrigger();
    logic [7:0] exp_b [8] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hBB, 8'hAA, 8'h99, 8'h88};
    bit ok;
    mem[12'h100] = 32'hCAFEF00D; mem[12'h101] = 32'h8899AABB; mem[12'h200] = 32'h55555555;
    start_dump(12'h100, 13'd2, 16'd2);
    repeat (30) @(negedge clk);
    #1; bus.start_addr_i = 12'h200; bus.num_words_i = 13'd1; bus.dump_i = 1'b1;
    @(negedge clk); #1; bus.dump_i = 1'b0;
    wait_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retrig_timeout done never seen"); end
    checks++; if (done_cyc - e0 + 1 != 165 + CS*20) begin errors++; $display("FAIL retrig_done_lat got %0d want %0d", done_cyc - e0 + 1, 165 + CS*20); end
    repeat (200) @(negedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL retrig_done_cnt got %0d want 1", done_cnt); end
    checks++; if (rd_q.size() != 2 || rd_q[0] !== 12'h100 || rd_q[1] !== 12'h101) begin errors++; $display("FAIL retrig_reads got n=%0d want 100,101", rd_q.size()); end
    checks++; if (by_q.size() != 8 + CS) begin errors++; $display("FAIL retrig_nbytes got %0d want %0d", by_q.size(), 8 + CS); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (by_q[i] !== exp_b[i]) begin errors++; $display("FAIL retrig_byte%0d got %h want %h", i, by_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid_dump();
    logic [7:0] exp_b [4] = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
    bit ok;
    mem[12'h300] = 32'h01234567; mem[12'h301] = 32'h76543210; mem[12'h400] = 32'h89ABCDEF;
    start_dump(12'h300, 13'd2, 16'd4);
    // byte 2 data bits occupy E0+86..E0+118
    while (cyc < e0 + 95) @(negedge clk);
    #1; rst = 1'b1; #1;
    checks++; if (bus.tx_o !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", bus.tx_o); end
    checks++; if (bus.csb_o !== 1'b1) begin errors++; $display("FAIL rstmid_csb got %b want 1", bus.csb_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy_o); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    start_dump(12'h400, 13'd1, 16'd2);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout done never seen"); end
    checks++; if (done_cyc - e0 + 1 != 83 + CS*20) begin errors++; $display("FAIL rstmid_done_lat got %0d want %0d", done_cyc - e0 + 1, 83 + CS*20); end
    checks++; if (rd_q.size() != 1 || rd_q[0] !== 12'h400) begin errors++; $display("FAIL rstmid_reads got n=%0d want 400", rd_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (by_q[i] !== exp_b[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, by_q[i], exp_b[i]); end
    end
  endtask

`ifdef ICCM_DUMPER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    mem[12'h050] = 32'h01020304; mem[12'h051] = 32'hFFFFFFFF;
    start_dump(12'h050, 13'd2, 16'd1);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL csum_timeout done never seen"); end
    checks++; if (by_q.size() != 9) begin errors++; $display("FAIL csum_nbytes got %0d want 9", by_q.size()); end
    checks++; if (by_q[8] !== 8'h06) begin errors++; $display("FAIL csum_value got %h want 06", by_q[8]); end
    checks++; if (st_q[8] - st_q[7] != 10) begin errors++; $display("FAIL csum_gap got %0d want 10", st_q[8] - st_q[7]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bus.dump_i = 1'b0; bus.start_addr_i = 12'h000; bus.num_words_i = 13'd0;
    bus.clks_per_bit_i = 16'd1; bus.rdata_i = 32'h0;
    test_reset();
    test_single_word();
    test_wrap();
    test_zero_count();
    test_cpb_zero();
    test_busy_retrigger();
    test_reset_mid_dump();
`ifdef ICCM_DUMPER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
